// File: rtl/espsid_pkg.sv
// Shared types and constants for the espSID chip-side logic: bus FSM states,
// SID bus widths, the latched request record and SID register map.
`timescale 1ns/1ps
package espsid_pkg;
    localparam int SID_AW = 5;
    localparam int SID_DW = 8;

    typedef enum logic [1:0] {
        SRST = 2'd0,
        IDLE = 2'd1,
        WAIT = 2'd2,
        ACT  = 2'd3
    } sid_state_e;

    typedef struct packed {
        logic              rw;
        logic [SID_AW-1:0] addr;
        logic [SID_DW-1:0] wdata;
    } sid_req_t;

    localparam logic [SID_AW-1:0] SID_V1_FREQ_LO = 5'h00;
    localparam logic [SID_AW-1:0] SID_V1_CTRL    = 5'h04;
    localparam logic [SID_AW-1:0] SID_V2_FREQ_LO = 5'h07;
    localparam logic [SID_AW-1:0] SID_V3_FREQ_LO = 5'h0E;
    localparam logic [SID_AW-1:0] SID_FC_LO      = 5'h15;
    localparam logic [SID_AW-1:0] SID_RES_FILT   = 5'h17;
    localparam logic [SID_AW-1:0] SID_MODE_VOL   = 5'h18;
    localparam logic [SID_AW-1:0] SID_POTX       = 5'h19;
    localparam logic [SID_AW-1:0] SID_POTY       = 5'h1A;
    localparam logic [SID_AW-1:0] SID_OSC3       = 5'h1B;
    localparam logic [SID_AW-1:0] SID_ENV3       = 5'h1C;
endpackage

// File: rtl/sid_bus_master_if.sv
// Request/response handshake between the ESP command decoder and the SID bus master.
`timescale 1ns/1ps
interface sid_bus_master_if ();
    import espsid_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [SID_AW-1:0] req_addr;
    logic [SID_DW-1:0] req_wdata;
    logic              rsp_valid;
    logic [SID_DW-1:0] rsp_rdata;

    // master = requester (command decoder), slave = sid_bus_master
    modport master (
        output req_valid, req_rw, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sid_phi_gen.sv
// phi2 generator: free-running divider producing sid_clk (low half first) and a
// strobe marking the last phi2-high clk, i.e. the clk before each period start.
`timescale 1ns/1ps
module sid_phi_gen #(
    parameter logic [7:0] CLK_DIV = 8'd100
) (
    input  logic clk,
    input  logic rst,
    output logic sid_clk,
    output logic last_high
);
    logic [7:0] ph_cnt_q, ph_cnt_d;
    logic       sid_clk_q, sid_clk_d;

    always_comb begin
        ph_cnt_d  = (ph_cnt_q == CLK_DIV - 8'd1) ? 8'd0 : ph_cnt_q + 8'd1;
        // registered from the next count so sid_clk lines up with ph_cnt
        sid_clk_d = (ph_cnt_d >= (CLK_DIV >> 1));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ph_cnt_q  <= 8'd0;
            sid_clk_q <= 1'b0;
        end else begin
            ph_cnt_q  <= ph_cnt_d;
            sid_clk_q <= sid_clk_d;
        end
    end

    assign sid_clk   = sid_clk_q;
    assign last_high = (ph_cnt_q == CLK_DIV - 8'd1);
endmodule

// File: rtl/sid_bus_master.sv
// SID bus initiator: sequences SID reset, then runs one phi2-aligned register
// read/write bus cycle per accepted request, one full phi2 period of chip select.
`timescale 1ns/1ps
module sid_bus_master
    import espsid_pkg::*;
#(
    parameter logic [7:0] CLK_DIV   = 8'd100,
    parameter logic [7:0] RESET_PHI = 8'd16
) (
    input  logic              clk,
    input  logic              rst,
    sid_bus_master_if.slave   bus,
    output logic              sid_clk,
    output logic              sid_res_n,
    output logic              sid_cs_n,
    output logic              sid_rw,
    output logic [SID_AW-1:0] sid_addr,
    output logic [SID_DW-1:0] sid_data_o,
    output logic              sid_data_oe,
    input  logic [SID_DW-1:0] sid_data_i
);
    sid_state_e        state_q, state_d;
    logic [7:0]        rst_cnt_q, rst_cnt_d;
    sid_req_t          req_q, req_d, cmd;
    logic              res_n_q, res_n_d;
    logic              cs_n_q, cs_n_d;
    logic              rw_q, rw_d;
    logic [SID_AW-1:0] addr_q, addr_d;
    logic [SID_DW-1:0] data_o_q, data_o_d;
    logic              oe_q, oe_d;
    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [SID_DW-1:0] rdata_q, rdata_d;
    logic              last_high, transfer, launch;

    sid_phi_gen #(.CLK_DIV(CLK_DIV)) u_phi (
        .clk       (clk),
        .rst       (rst),
        .sid_clk   (sid_clk),
        .last_high (last_high)
    );

    assign transfer = bus.req_valid & ready_q;

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        req_d       = req_q;
        res_n_d     = res_n_q;
        cs_n_d      = cs_n_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        data_o_d    = data_o_q;
        oe_d        = oe_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        cmd         = req_q;
        launch      = 1'b0;

        case (state_q)
            SRST: begin
                res_n_d = 1'b0;
                ready_d = 1'b0;
                if (last_high) begin
                    if (rst_cnt_q == RESET_PHI - 8'd1) begin
                        rst_cnt_d = 8'd0;
                        res_n_d   = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        rst_cnt_d = rst_cnt_q + 8'd1;
                    end
                end
            end
            IDLE: begin
                ready_d = 1'b1;
                if (transfer) begin
                    ready_d     = 1'b0;
                    req_d.rw    = bus.req_rw;
                    req_d.addr  = bus.req_addr;
                    req_d.wdata = bus.req_wdata;
                    cmd         = req_d;
                    state_d     = WAIT;
                    // accepted on the last clk of a period: CS starts next clk
                    launch      = last_high;
                end
            end
            WAIT: launch = last_high;
            ACT: begin
                if (last_high) begin
                    if (req_q.rw) rdata_d = sid_data_i;
                    cs_n_d      = 1'b1;
                    rw_d        = 1'b1;
                    oe_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = SRST;
        endcase

        if (launch) begin
            cs_n_d  = 1'b0;
            rw_d    = cmd.rw;
            addr_d  = cmd.addr;
            state_d = ACT;
            if (!cmd.rw) begin
                data_o_d = cmd.wdata;
                oe_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= SRST;
            rst_cnt_q   <= 8'd0;
            req_q       <= '0;
            res_n_q     <= 1'b0;
            cs_n_q      <= 1'b1;
            rw_q        <= 1'b1;
            addr_q      <= '0;
            data_o_q    <= '0;
            oe_q        <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            req_q       <= req_d;
            res_n_q     <= res_n_d;
            cs_n_q      <= cs_n_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            data_o_q    <= data_o_d;
            oe_q        <= oe_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    assign sid_res_n     = res_n_q;
    assign sid_cs_n      = cs_n_q;
    assign sid_rw        = rw_q;
    assign sid_addr      = addr_q;
    assign sid_data_o    = data_o_q;
    assign sid_data_oe   = oe_q;
    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_sid_bus_master.sv
// Bench for sid_bus_master with CLK_DIV=8, RESET_PHI=4: vector table of accesses,
// scoreboard of expected bus cycles/responses, plus reset and timing sequences.
`timescale 1ns/1ps
module tb_sid_bus_master;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] sid_data_i = 8'h00;
    logic       sid_clk, sid_res_n, sid_cs_n, sid_rw, sid_data_oe;
    logic [4:0] sid_addr;
    logic [7:0] sid_data_o;

    sid_bus_master_if bus ();

    sid_bus_master #(.CLK_DIV(8'd8), .RESET_PHI(8'd4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .sid_clk     (sid_clk),
        .sid_res_n   (sid_res_n),
        .sid_cs_n    (sid_cs_n),
        .sid_rw      (sid_rw),
        .sid_addr    (sid_addr),
        .sid_data_o  (sid_data_o),
        .sid_data_oe (sid_data_oe),
        .sid_data_i  (sid_data_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [4:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        int unsigned start;
    } txn_t;

    typedef struct {
        logic       rw;
        logic [4:0] addr;
        logic [7:0] wdata;
        logic [7:0] din;
        int         ph;
    } vec_t;

    txn_t        sb[$];
    txn_t        mt;
    vec_t        vecs[7];
    int          n_chk = 0, n_fail = 0;
    int          cs_len = 0, clk_bad = 0, oe_rw_bad = 0, rsp_cnt = 0;
    int unsigned cyc = 0;
    logic [2:0]  ph = 3'd0;
    logic [2:0]  last_acc_ph = 3'd0;

    // reference phase: phi2 period of 8 clks restarting from reset
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ph  <= !rst ? 3'd0 : ph + 3'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: bus cycle contents against scoreboard head, responses popped in order
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            cs_len = 0;
        end else begin
            if (sid_clk !== (ph >= 3'd4)) clk_bad++;
            if (sid_data_oe && sid_rw) oe_rw_bad++;
            if (!sid_cs_n) begin
                if (cs_len == 0) begin
                    chk("cs_has_txn", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        mt = sb[0];
                        chk("cs_start_cycle", cyc, mt.start);
                        chk("cs_rw", sid_rw, mt.rw);
                        chk("cs_addr", sid_addr, mt.addr);
                        chk("cs_oe", sid_data_oe, !mt.rw);
                        if (!mt.rw) chk("cs_data_o", sid_data_o, mt.wdata);
                    end
                end
                cs_len++;
            end
            if (bus.rsp_valid) begin
                rsp_cnt++;
                chk("rsp_has_txn", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    mt = sb.pop_front();
                    chk("cs_len", cs_len, 8);
                    chk("cs_released", {sid_cs_n, sid_data_oe, sid_rw}, 3'b101);
                    if (mt.rw) chk("rsp_rdata", bus.rsp_rdata, mt.rdata);
                end
                cs_len = 0;
            end
        end
    end

    // Drive one request; tgt >= 0 delays valid until that phase. keep leaves valid high.
    task automatic issue(input logic rw, input logic [4:0] addr, input logic [7:0] wdata,
                         input logic [7:0] rdata, input int tgt, input bit keep);
        txn_t t;
        bus.req_rw    = rw;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        if (tgt < 0) bus.req_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (bus.req_ready && (tgt < 0 || int'(ph) == tgt)) break;
            @(negedge clk);
        end
        chk("req_ready_seen", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        t.rw = rw; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        t.start = cyc + 32'd8 - 32'(ph);
        last_acc_ph = ph;
        sb.push_back(t);
        @(negedge clk);
        chk("ready_drop", bus.req_ready, 0);
        if (!keep) begin
            bus.req_valid = 1'b0;
            bus.req_rw    = ~rw;
            bus.req_addr  = ~addr;
            bus.req_wdata = ~wdata;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 64 && sb.size() != 0; i++) @(negedge clk);
        chk("rsp_pending", sb.size(), 0);
    endtask

    task automatic release_and_wait_res();
        int n = 0;
        rst = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (sid_res_n) break;
        end
        chk("res_n_rise_clks", n, 32);
        chk("ready_at_res_rise", bus.req_ready, 0);
        @(negedge clk);
        chk("ready_after_res", bus.req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, rises;
        logic prev;
        vecs[0] = '{1'b0, 5'h18, 8'h0F, 8'h00, 3};
        vecs[1] = '{1'b1, 5'h1B, 8'h00, 8'hA5, 2};
        vecs[2] = '{1'b0, 5'h00, 8'h55, 8'h00, 0};
        vecs[3] = '{1'b0, 5'h1F, 8'hAA, 8'h00, 7};
        vecs[4] = '{1'b1, 5'h1C, 8'h00, 8'h3C, 7};
        vecs[5] = '{1'b1, 5'h19, 8'h00, 8'h00, 0};
        vecs[6] = '{1'b0, 5'h05, 8'hFF, 8'h00, 5};

        bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        repeat (10) @(negedge clk);
        chk("rst_sid_clk", sid_clk, 0);
        chk("rst_res_n", sid_res_n, 0);
        chk("rst_cs_n", sid_cs_n, 1);
        chk("rst_rw", sid_rw, 1);
        chk("rst_addr", sid_addr, 0);
        chk("rst_data_o", sid_data_o, 0);
        chk("rst_oe", sid_data_oe, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rdata", bus.rsp_rdata, 0);

        release_and_wait_res();

        hi = 0; rises = 0; prev = sid_clk;
        repeat (16) begin
            @(negedge clk);
            if (sid_clk) hi++;
            if (sid_clk && !prev) rises++;
            prev = sid_clk;
        end
        chk("sid_clk_high_clks", hi, 8);
        chk("sid_clk_rises", rises, 2);

        foreach (vecs[k]) begin
            sid_data_i = vecs[k].rw ? vecs[k].din : 8'hC3;
            issue(vecs[k].rw, vecs[k].addr, vecs[k].wdata, vecs[k].din, vecs[k].ph, 1'b0);
            wait_idle();
        end

        // read: data valid only during phi2-high, changed right after the sample point
        sid_data_i = 8'h00;
        issue(1'b1, 5'h1B, 8'h00, 8'hA5, -1, 1'b0);
        for (int i = 0; i < 64 && !(!sid_cs_n && ph == 3'd4); i++) @(negedge clk);
        sid_data_i = 8'hA5;
        for (int i = 0; i < 64 && !bus.rsp_valid; i++) @(negedge clk);
        chk("rd_rsp_seen", bus.rsp_valid, 1);
        sid_data_i = 8'h5A;
        @(negedge clk);
        chk("rd_rdata_hold", bus.rsp_rdata, 8'hA5);
        chk("rsp_one_clk", bus.rsp_valid, 0);

        // back-to-back writes with valid held
        issue(1'b0, 5'h00, 8'h11, 8'h00, -1, 1'b1);
        issue(1'b0, 5'h01, 8'h22, 8'h00, -1, 1'b1);
        chk("b2b_accept_ph_2", last_acc_ph, 1);
        issue(1'b0, 5'h02, 8'h33, 8'h00, -1, 1'b0);
        chk("b2b_accept_ph_3", last_acc_ph, 1);
        wait_idle();

        // reset in the middle of a write bus cycle
        issue(1'b0, 5'h04, 8'h21, 8'h00, -1, 1'b0);
        for (int i = 0; i < 64 && sid_cs_n; i++) @(negedge clk);
        chk("mid_act_cs_seen", sid_cs_n, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_bus", {sid_cs_n, sid_data_oe, sid_res_n, sid_rw}, 4'b1001);
        chk("mid_rst_hs", {bus.req_ready, bus.rsp_valid}, 2'b00);
        repeat (2) @(negedge clk);
        release_and_wait_res();

        issue(1'b0, 5'h18, 8'h1F, 8'h00, 7, 1'b0);
        wait_idle();

        chk("sid_clk_vs_phase", clk_bad, 0);
        chk("oe_while_read", oe_rw_bad, 0);
        chk("rsp_count", rsp_cnt, 12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
